pmod_i2s2_axil_regs: RTL

AXI4-Lite slave register file for the Pmod I2S2 IP. It terminates the S00_AXI port driven by the AXI VIP master in the block-level bench and by the PS in the full design. It holds four 32-bit control registers that feed the I2S core, and it emits a one-cycle commit pulse per register write. Write and read channels run independently; each has one transaction outstanding.

---
 rtl/pmod_i2s2_axil_pkg.sv | 35 +++
 rtl/pmod_i2s2_axil_regs.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pmod_i2s2_axil_pkg.sv
// Shared definitions for the Pmod I2S2 AXI4-Lite register file.
package pmod_i2s2_axil_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_TXL  = 2'd1;
  localparam logic [1:0] REG_TXR  = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Byte-lane merge: lanes with a set strobe take the new byte, others keep the old one.
  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pmod_i2s2_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the Pmod I2S2 core.
// Write and read channels are independent FSMs, each with one transaction in flight.
module pmod_i2s2_axil_regs
  import pmod_i2s2_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);

  wr_state_t   wr_state, wr_next;
  rd_state_t   rd_state, rd_next;

  logic [1:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [31:0] regs [4];

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  commit_idx;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;
  logic [31:0] rd_mux;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bresp = RESP_OKAY;
  assign s00_axi_rresp = RESP_OKAY;

  assign slv_reg0 = regs[REG_CTRL];
  assign slv_reg1 = regs[REG_TXL];
  assign slv_reg2 = regs[REG_TXR];
  assign slv_reg3 = regs[REG_CFG];

  // Write FSM: readies from state, next state, and the commit decision on entry to W_RESP.
  always_comb begin
    s00_axi_awready = (wr_state == W_IDLE) || (wr_state == W_HAVE_W);
    s00_axi_wready  = (wr_state == W_IDLE) || (wr_state == W_HAVE_AW);
    s00_axi_bvalid  = (wr_state == W_RESP);
    aw_hs   = s00_axi_awvalid && s00_axi_awready;
    w_hs    = s00_axi_wvalid  && s00_axi_wready;
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_RESP;
        else if (aw_hs)    wr_next = W_HAVE_AW;
        else if (w_hs)     wr_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wr_next = W_RESP;
      W_HAVE_W:  if (aw_hs) wr_next = W_RESP;
      W_RESP:    if (s00_axi_bready) wr_next = W_IDLE;
      default:   wr_next = W_IDLE;
    endcase
    commit      = (wr_next == W_RESP) && (wr_state != W_RESP);
    commit_idx  = (wr_state == W_HAVE_AW) ? aw_idx : s00_axi_awaddr[3:2];
    commit_data = (wr_state == W_HAVE_W)  ? w_data : s00_axi_wdata;
    commit_strb = (wr_state == W_HAVE_W)  ? w_strb : s00_axi_wstrb;
  end

  // Write state, latched half-transactions, register commit and the one-cycle commit pulse.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state     <= W_IDLE;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) aw_idx <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      reg_wr_pulse <= '0;
      if (commit) begin
        reg_wr_pulse[commit_idx] <= 1'b1;
        regs[commit_idx]         <= merge(regs[commit_idx], commit_data, commit_strb);
      end
    end
  end

  // Read FSM: arready/rvalid from state, next state, and the register select for rdata.
  always_comb begin
    s00_axi_arready = (rd_state == R_IDLE);
    s00_axi_rvalid  = (rd_state == R_DATA);
    ar_hs   = s00_axi_arvalid && s00_axi_arready;
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s00_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    rd_mux = regs[REG_CTRL];
    unique case (s00_axi_araddr[3:2])
      REG_CTRL: rd_mux = regs[REG_CTRL];
      REG_TXL:  rd_mux = regs[REG_TXL];
      REG_TXR:  rd_mux = regs[REG_TXR];
      REG_CFG:  rd_mux = regs[REG_CFG];
      default:  rd_mux = regs[REG_CTRL];
    endcase
  end

  // Read state and rdata capture; sampling pre-edge contents gives old data on a same-edge write.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_state      <= R_IDLE;
      s00_axi_rdata <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) s00_axi_rdata <= rd_mux;
    end
  end

endmodule
